// File: rtl/light_pkg.sv
// Shared types and constants for the line-pattern selector sequencer.
package light_pkg;
  localparam int SEL_W            = 6;
  localparam int DEFAULT_LAST_SEL = 59;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;
endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles and flags the last one of every CLK_DIV-cycle period.
module tick_gen #(
  parameter int CLK_DIV = 25000000,
  parameter int DIV_W   = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  assign tick = en && (count_q == LAST_CNT);

  // The count only moves on enabled cycles, so a frozen value resumes exactly where it stopped.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/light_sequencer.sv
// Steps the shared line-pattern selector through 0..LAST_SEL at a prescaled rate,
// with start/stop/pause control and one-shot or looping frames.
module light_sequencer
  import light_pkg::*;
#(
  parameter int CLK_DIV  = 25000000,
  parameter int LAST_SEL = DEFAULT_LAST_SEL,
  parameter int DIV_W    = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop,
  output logic [SEL_W-1:0] sel,
  output logic             running,
  output logic             step,
  output logic             frame_done
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(LAST_SEL);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             running_q, running_d;
  logic             step_q, step_d;
  logic             frame_done_q, frame_done_d;
  logic             div_clr;
  logic             div_en;
  logic             tick;

  // Prescaler advances only on cycles where neither stop nor pause is holding the frame.
  assign div_clr = (state_q == S_IDLE) || stop;
  assign div_en  = (state_q != S_IDLE) && !stop && !pause;

  tick_gen #(
    .CLK_DIV(CLK_DIV),
    .DIV_W  (DIV_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (div_clr),
    .en   (div_en),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    running_d    = running_q;
    step_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d   = S_RUN;
          sel_d     = '0;
          running_d = 1'b1;
        end
      end
      S_RUN, S_PAUSE: begin
        if (stop) begin
          state_d   = S_IDLE;
          sel_d     = '0;
          running_d = 1'b0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else begin
          // A release cycle counts as a running cycle, so pausing never loses step time.
          state_d = S_RUN;
          if (tick) begin
            step_d = 1'b1;
            if (sel_q == LAST) begin
              sel_d        = '0;
              frame_done_d = 1'b1;
              if (!loop) begin
                state_d   = S_IDLE;
                running_d = 1'b0;
              end
            end else begin
              sel_d = sel_q + SEL_W'(1);
            end
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        sel_d     = '0;
        running_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      running_q    <= 1'b0;
      step_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      running_q    <= running_d;
      step_q       <= step_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign sel        = sel_q;
  assign running    = running_q;
  assign step       = step_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: two instances (CLK_DIV=4/LAST_SEL=59 and CLK_DIV=1/LAST_SEL=0)
// compared every cycle against a cycle-count model, plus hand-computed checkpoints.
module tb_light_sequencer;
  localparam int CD_A = 4;
  localparam int LS_A = 59;
  localparam int CD_B = 1;
  localparam int LS_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start[2];
  logic       stop[2];
  logic       pause[2];
  logic       loop_i[2];
  logic [5:0] sel[2];
  logic       running[2];
  logic       step[2];
  logic       frame_done[2];

  int tests = 0;
  int fails = 0;
  int cd[2] = '{CD_A, CD_B};
  int ls[2] = '{LS_A, LS_B};

  // Model: a running frame is a count of un-paused cycles; every cd-th one is a step.
  bit m_run[2];
  int m_sel[2];
  int m_phase[2];
  bit m_step[2];
  bit m_fd[2];

  always #5 clk = ~clk;

  light_sequencer #(.CLK_DIV(CD_A), .LAST_SEL(LS_A), .DIV_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .pause(pause[0]),
    .loop(loop_i[0]), .sel(sel[0]), .running(running[0]), .step(step[0]),
    .frame_done(frame_done[0])
  );

  light_sequencer #(.CLK_DIV(CD_B), .LAST_SEL(LS_B), .DIV_W(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .pause(pause[1]),
    .loop(loop_i[1]), .sel(sel[1]), .running(running[1]), .step(step[1]),
    .frame_done(frame_done[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i, input bit s, input bit sp, input bit p, input bit l);
    start[i]  = s;
    stop[i]   = sp;
    pause[i]  = p;
    loop_i[i] = l;
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_run[i] = 0; m_sel[i] = 0; m_phase[i] = 0; m_step[i] = 0; m_fd[i] = 0;
      end else begin
        m_step[i] = 0;
        m_fd[i]   = 0;
        if (!m_run[i]) begin
          if (start[i] && !stop[i]) begin
            m_run[i] = 1; m_sel[i] = 0; m_phase[i] = 0;
          end
        end else if (stop[i]) begin
          m_run[i] = 0; m_sel[i] = 0; m_phase[i] = 0;
        end else if (!pause[i]) begin
          m_phase[i]++;
          if (m_phase[i] == cd[i]) begin
            m_phase[i] = 0;
            m_step[i]  = 1;
            if (m_sel[i] == ls[i]) begin
              m_sel[i] = 0;
              m_fd[i]  = 1;
              if (!loop_i[i]) m_run[i] = 0;
            end else begin
              m_sel[i]++;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("model%0d.sel", i), 32'(sel[i]), 32'(m_sel[i]));
        checkOutput($sformatf("model%0d.running", i), 32'(running[i]), 32'(m_run[i]));
        checkOutput($sformatf("model%0d.step", i), 32'(step[i]), 32'(m_step[i]));
        checkOutput($sformatf("model%0d.frame_done", i), 32'(frame_done[i]), 32'(m_fd[i]));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int f1;
    int f2;
    bit dropped;
    for (int i = 0; i < 2; i++) applyStimulus(i, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("reset.sel", 32'(sel[i]), 0);
      checkOutput("reset.running", 32'(running[i]), 0);
      checkOutput("reset.step", 32'(step[i]), 0);
      checkOutput("reset.frame_done", 32'(frame_done[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle 0: start both; B loops with CLK_DIV=1, LAST_SEL=0
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("a.c1.running", 32'(running[0]), 1);
    checkOutput("a.c1.sel", 32'(sel[0]), 0);
    checkOutput("a.c1.step", 32'(step[0]), 0);
    checkOutput("b.c1.running", 32'(running[1]), 1);
    checkOutput("b.c1.step", 32'(step[1]), 0);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checkOutput("a.no_early_step", 32'(step[0]), 0);
      checkOutput("b.every_cycle_fd", 32'(frame_done[1]), 1);
      checkOutput("b.every_cycle_step", 32'(step[1]), 1);
      checkOutput("b.sel_zero", 32'(sel[1]), 0);
    end
    @(negedge clk);
    checkOutput("a.c5.sel", 32'(sel[0]), 1);
    checkOutput("a.c5.step", 32'(step[0]), 1);
    repeat (4) @(negedge clk);
    checkOutput("a.c9.sel", 32'(sel[0]), 2);
    checkOutput("a.c9.step", 32'(step[0]), 1);
    applyStimulus(1, 0, 1, 0, 1);
    @(negedge clk);
    checkOutput("b.stop.running", 32'(running[1]), 0);
    applyStimulus(1, 0, 0, 0, 0);

    // One-shot frame ends at cycle 241
    repeat (230) @(negedge clk);
    checkOutput("a.c240.sel", 32'(sel[0]), 59);
    checkOutput("a.c240.running", 32'(running[0]), 1);
    @(negedge clk);
    checkOutput("a.wrap.sel", 32'(sel[0]), 0);
    checkOutput("a.wrap.frame_done", 32'(frame_done[0]), 1);
    checkOutput("a.wrap.step", 32'(step[0]), 1);
    checkOutput("a.wrap.running", 32'(running[0]), 0);
    @(negedge clk);
    checkOutput("a.after_wrap.frame_done", 32'(frame_done[0]), 0);
    checkOutput("a.after_wrap.running", 32'(running[0]), 0);

    // Looping: two frame_done pulses 240 cycles apart
    applyStimulus(0, 1, 0, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("loop.restart.sel", 32'(sel[0]), 0);
    f1 = -1;
    f2 = -1;
    dropped = 0;
    for (int c = 2; c <= 500; c++) begin
      @(negedge clk);
      if (!running[0]) dropped = 1;
      if (frame_done[0]) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
    end
    checkOutput("loop.first_fd_cycle", 32'(f1), 241);
    checkOutput("loop.fd_spacing", 32'(f2 - f1), 240);
    checkOutput("loop.running_held", 32'(dropped), 0);
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("loop.stop.running", 32'(running[0]), 0);
    checkOutput("loop.stop.sel", 32'(sel[0]), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Pause at div_cnt=2, sel=7 (cycle 31) for 10 cycles
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (30) @(negedge clk);
    checkOutput("pause.c31.sel", 32'(sel[0]), 7);
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput("pause.hold.sel", 32'(sel[0]), 7);
      checkOutput("pause.hold.step", 32'(step[0]), 0);
      checkOutput("pause.hold.running", 32'(running[0]), 1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pause.c42.sel", 32'(sel[0]), 7);
    @(negedge clk);
    checkOutput("pause.c43.sel", 32'(sel[0]), 8);
    checkOutput("pause.c43.step", 32'(step[0]), 1);
    repeat (3) @(negedge clk);
    applyStimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pause_at_last.step", 32'(step[0]), 0);
    checkOutput("pause_at_last.sel", 32'(sel[0]), 8);
    @(negedge clk);
    checkOutput("pause_at_last.c48.sel", 32'(sel[0]), 9);
    checkOutput("pause_at_last.c48.step", 32'(step[0]), 1);

    // Stop while paused at sel=30
    repeat (84) @(negedge clk);
    checkOutput("pstop.c132.sel", 32'(sel[0]), 30);
    applyStimulus(0, 0, 0, 1, 0);
    @(negedge clk);
    applyStimulus(0, 0, 1, 1, 0);
    @(negedge clk);
    checkOutput("pstop.sel", 32'(sel[0]), 0);
    checkOutput("pstop.running", 32'(running[0]), 0);
    applyStimulus(0, 1, 1, 0, 0);
    @(negedge clk);
    checkOutput("idle.start_stop.running", 32'(running[0]), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Asynchronous reset mid-frame at sel=42
    applyStimulus(0, 1, 0, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1);
    repeat (168) @(negedge clk);
    checkOutput("areset.pre.sel", 32'(sel[0]), 42);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset.sel", 32'(sel[0]), 0);
    checkOutput("areset.running", 32'(running[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic on both instances
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        applyStimulus(i, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
